// File: rtl/risc_v_mike_pkg.sv
// -----------------------------------------------------------------------------
// risc_v_mike_pkg
// Shared constants and types for the risc_v_mike GPIO input path.
//   GPIO_BYTE            : width of one GPIO port (pins per port)
//   GPIO_DEBOUNCE_CYCLES : default number of consecutive differing samples
//                          needed before a pin change is accepted
//   gpio_vec_t           : one GPIO port vector
//   cnt_width()          : debounce counter width, never narrower than 1 bit
// -----------------------------------------------------------------------------
package risc_v_mike_pkg;

   localparam int GPIO_BYTE            = 8;
   localparam int GPIO_DEBOUNCE_CYCLES = 4;

   typedef logic [GPIO_BYTE-1:0] gpio_vec_t;

   // The counter only has to reach cycles-1, so $clog2(cycles) bits suffice.
   // A 1-cycle filter still gets a 1-bit counter that simply stays at 0.
   function automatic int cnt_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/risc_v_mike_gpio_debounce_bit.sv
// -----------------------------------------------------------------------------
// risc_v_mike_gpio_debounce_bit
// One pin of the GPIO input conditioner: a 2-flop synchronizer, a debounce
// counter and the accepted (stable) level, plus one-cycle rise/fall pulses
// that are high exactly while the next edge commits a new stable level.
// Ports:
//   clk          in  system clock, rising edge
//   rst          in  synchronous active-high reset
//   i_pin_async  in  raw asynchronous pin level
//   o_stable     out debounced level
//   o_rise       out stable will go 0->1 on the next clock edge
//   o_fall       out stable will go 1->0 on the next clock edge
// Parameter DEBOUNCE_CYCLES must be >= 1.
// -----------------------------------------------------------------------------
module risc_v_mike_gpio_debounce_bit
   import risc_v_mike_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic i_pin_async,
   output logic o_stable,
   output logic o_rise,
   output logic o_fall
);

   localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;

   logic w_differs;
   logic w_accept;

   assign w_differs = (r_sync2 != r_stable);
   // The sample that completes the window is itself counted, so the change
   // is committed while the counter already reads DEBOUNCE_CYCLES-1.
   assign w_accept  = w_differs && (r_cnt == CNT_LAST);

   // NOTE: every register here is assigned with <= so that r_sync2 samples the
   // pre-edge r_sync1; a blocking '=' would collapse the synchronizer to one
   // flop and let a metastable value straight into the debounce logic.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_pin_async;
         r_sync2 <= r_sync1;
         if (!w_differs) begin
            // Any sample matching the accepted level restarts the window.
            r_cnt <= '0;
         end else if (w_accept) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_stable = r_stable;
   assign o_rise   = w_accept &  r_sync2;
   assign o_fall   = w_accept & ~r_sync2;

endmodule

// File: rtl/risc_v_mike_gpio_in_cond.sv
// -----------------------------------------------------------------------------
// risc_v_mike_gpio_in_cond
// Input-conditioning stage in front of the core's gpio_port_in. Each pin is
// synchronized, debounced and edge-detected independently; optionally the
// edges are latched into sticky flags that drive an interrupt request.
// Ports:
//   clk        in  system clock, rising edge
//   rst        in  synchronous active-high reset
//   pin_async  in  [GPIO_W] raw asynchronous pin levels
//   gpio_in    out [GPIO_W] debounced levels (to core gpio_port_in)
//   rise_en    in  [GPIO_W] per-bit enable of rise flags into irq
//   fall_en    in  [GPIO_W] per-bit enable of fall flags into irq
//   flag_clr   in  [GPIO_W] write-1-to-clear pulse for both flags of a bit
//   rise_flag  out [GPIO_W] sticky rising-edge flags
//   fall_flag  out [GPIO_W] sticky falling-edge flags
//   irq        out OR of enabled flags
// Build option: define RISC_V_MIKE_GPIO_EDGE_IRQ_EN to build the edge flags
// and irq. Without it the flags and irq read 0 and rise_en/fall_en/flag_clr
// are ignored; ports and gpio_in timing are unchanged.
// -----------------------------------------------------------------------------
module risc_v_mike_gpio_in_cond
   import risc_v_mike_pkg::*;
#(
   parameter int GPIO_W          = GPIO_BYTE,
   parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [GPIO_W-1:0] pin_async,
   output logic [GPIO_W-1:0] gpio_in,
   input  logic [GPIO_W-1:0] rise_en,
   input  logic [GPIO_W-1:0] fall_en,
   input  logic [GPIO_W-1:0] flag_clr,
   output logic [GPIO_W-1:0] rise_flag,
   output logic [GPIO_W-1:0] fall_flag,
   output logic              irq
);

   logic [GPIO_W-1:0] w_stable;
   logic [GPIO_W-1:0] w_rise;
   logic [GPIO_W-1:0] w_fall;

   for (genvar gi = 0; gi < GPIO_W; gi++) begin : g_bit
      risc_v_mike_gpio_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk         (clk),
         .rst         (rst),
         .i_pin_async (pin_async[gi]),
         .o_stable    (w_stable[gi]),
         .o_rise      (w_rise[gi]),
         .o_fall      (w_fall[gi])
      );
   end

   assign gpio_in = w_stable;

`ifdef RISC_V_MIKE_GPIO_EDGE_IRQ_EN
   logic [GPIO_W-1:0] r_rise_flag;
   logic [GPIO_W-1:0] r_fall_flag;

   // The pulses are high on the same edge that updates the stable level, so
   // the flags become visible together with the new gpio_in value. Clear is
   // applied first and the set ORed in afterwards: a coincident set wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rise_flag <= '0;
         r_fall_flag <= '0;
      end else begin
         r_rise_flag <= (r_rise_flag & ~flag_clr) | w_rise;
         r_fall_flag <= (r_fall_flag & ~flag_clr) | w_fall;
      end
   end

   assign rise_flag = r_rise_flag;
   assign fall_flag = r_fall_flag;
   assign irq       = |((r_rise_flag & rise_en) | (r_fall_flag & fall_en));
`else
   assign rise_flag = '0;
   assign fall_flag = '0;
   assign irq       = 1'b0;

   // Inputs and edge pulses kept on the interface but deliberately unused.
   logic w_unused_ok;
   assign w_unused_ok = ^{rise_en, fall_en, flag_clr, w_rise, w_fall};
`endif

endmodule

// File: tb/tb_risc_v_mike_gpio_in_cond.sv
// -----------------------------------------------------------------------------
// tb_risc_v_mike_gpio_in_cond
// Directed bench for risc_v_mike_gpio_in_cond (default GPIO_W=8, DEBOUNCE=4).
// The driver applies inputs, advances one rising edge and pushes the
// hand-computed post-edge state into a scoreboard queue; an independent
// monitor pops one entry per falling edge and compares it with the outputs.
// Flag/irq expectations collapse to 0 when RISC_V_MIKE_GPIO_EDGE_IRQ_EN is
// not defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_risc_v_mike_gpio_in_cond;
   import risc_v_mike_pkg::*;

   typedef gpio_vec_t vec_t;

   typedef struct {
      vec_t  gpio;
      vec_t  rf;
      vec_t  ff;
      logic  irq;
      string tag;
   } exp_t;

`ifdef RISC_V_MIKE_GPIO_EDGE_IRQ_EN
   localparam bit FLAGS_ON = 1'b1;
`else
   localparam bit FLAGS_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   vec_t pin_async;
   vec_t rise_en;
   vec_t fall_en;
   vec_t flag_clr;
   vec_t gpio_in;
   vec_t rise_flag;
   vec_t fall_flag;
   logic irq;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   risc_v_mike_gpio_in_cond dut (
      .clk       (clk),
      .rst       (rst),
      .pin_async (pin_async),
      .gpio_in   (gpio_in),
      .rise_en   (rise_en),
      .fall_en   (fall_en),
      .flag_clr  (flag_clr),
      .rise_flag (rise_flag),
      .fall_flag (fall_flag),
      .irq       (irq)
   );

   task automatic check(input string tag, input string what, input vec_t act, input vec_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s %s: got 0x%02h, expected 0x%02h (t=%0t)", tag, what, act, exp, $time);
      end
   endtask

   // Advance one rising edge with the inputs currently driven, then queue
   // the state the DUT must show after that edge.
   task automatic cyc(input vec_t g, input vec_t rf, input vec_t ff, input logic irq_e,
                      input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      e.gpio = g;
      e.rf   = FLAGS_ON ? rf : '0;
      e.ff   = FLAGS_ON ? ff : '0;
      e.irq  = FLAGS_ON ? irq_e : 1'b0;
      e.tag  = tag;
      sb_q.push_back(e);
   endtask

   // Monitor: one comparison set per entry, sampled mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check(e.tag, "gpio_in",   gpio_in,   e.gpio);
            check(e.tag, "rise_flag", rise_flag, e.rf);
            check(e.tag, "fall_flag", fall_flag, e.ff);
            check(e.tag, "irq",       vec_t'(irq), vec_t'(e.irq));
         end
      end
   end

   initial begin
      int pat[5] = '{1, 0, 1, 1, 0};

      rst       = 1'b1;
      pin_async = 8'hFF;
      rise_en   = 8'h00;
      fall_en   = 8'h00;
      flag_clr  = 8'h00;

      // 1. Reset with pins high, then release: edge 6 accepts all bits.
      repeat (3) cyc(8'h00, 8'h00, 8'h00, 1'b0, "t1_reset");
      rst = 1'b0;
      for (int e = 1; e <= 6; e++)
         cyc((e >= 6) ? 8'hFF : 8'h00, (e >= 6) ? 8'hFF : 8'h00, 8'h00, 1'b0, "t1_release");
      flag_clr = 8'hFF;
      cyc(8'hFF, 8'h00, 8'h00, 1'b0, "t1_clear");
      flag_clr = 8'h00;

      // 2. Clean step on bit 0 after a reset with pins low.
      rst       = 1'b1;
      pin_async = 8'h00;
      cyc(8'h00, 8'h00, 8'h00, 1'b0, "t2_reset");
      rst     = 1'b0;
      rise_en = 8'h01;
      repeat (2) cyc(8'h00, 8'h00, 8'h00, 1'b0, "t2_idle");
      pin_async = 8'h01;
      for (int e = 1; e <= 8; e++)
         cyc((e >= 6) ? 8'h01 : 8'h00, (e >= 6) ? 8'h01 : 8'h00, 8'h00, (e >= 6), "t2_step");

      // 3. Three-sample glitch on bit 3 never reaches gpio_in.
      flag_clr = 8'h01;
      cyc(8'h01, 8'h00, 8'h00, 1'b0, "t3_clear");
      flag_clr = 8'h00;
      rise_en  = 8'h08;
      pin_async = 8'h09;
      repeat (3) cyc(8'h01, 8'h00, 8'h00, 1'b0, "t3_glitch_hi");
      pin_async = 8'h01;
      repeat (8) cyc(8'h01, 8'h00, 8'h00, 1'b0, "t3_glitch_lo");

      // 4. Bounce 1,0,1,1,0 on bit 5 then steady 1 from edge 6: accepted at edge 11.
      rise_en = 8'h20;
      fall_en = 8'h20;
      for (int e = 1; e <= 12; e++) begin
         pin_async = (e <= 5 && pat[e-1] == 0) ? 8'h01 : 8'h21;
         cyc((e >= 11) ? 8'h21 : 8'h01, (e >= 11) ? 8'h20 : 8'h00, 8'h00, (e >= 11), "t4_bounce");
      end

      // 5. Clear racing flag updates on bit 2.
      rise_en   = 8'h04;
      fall_en   = 8'h04;
      pin_async = 8'h25;
      for (int e = 1; e <= 6; e++)
         cyc((e >= 6) ? 8'h25 : 8'h21, (e >= 6) ? 8'h24 : 8'h20, 8'h00, (e >= 6), "t5_rise_b2");
      pin_async = 8'h21;
      for (int e = 1; e <= 6; e++) begin
         flag_clr = (e == 6) ? 8'h04 : 8'h00;
         cyc((e >= 6) ? 8'h21 : 8'h25, (e >= 6) ? 8'h20 : 8'h24,
             (e >= 6) ? 8'h04 : 8'h00, 1'b1, "t5_fall_vs_clr");
      end
      flag_clr  = 8'h00;
      pin_async = 8'h25;
      for (int e = 1; e <= 6; e++) begin
         flag_clr = (e == 6) ? 8'h04 : 8'h00;
         cyc((e >= 6) ? 8'h25 : 8'h21, 8'h20 | ((e >= 6) ? 8'h04 : 8'h00),
             (e >= 6) ? 8'h00 : 8'h04, 1'b1, "t5_rise_vs_clr");
      end
      flag_clr = 8'h00;

      // 6. Reset mid-debounce on bit 7 discards progress; a full new window follows.
      rst       = 1'b1;
      pin_async = 8'h00;
      cyc(8'h00, 8'h00, 8'h00, 1'b0, "t6_reset");
      rst     = 1'b0;
      rise_en = 8'h80;
      fall_en = 8'h00;
      repeat (2) cyc(8'h00, 8'h00, 8'h00, 1'b0, "t6_idle");
      pin_async = 8'h80;
      repeat (4) cyc(8'h00, 8'h00, 8'h00, 1'b0, "t6_pre_reset");
      rst = 1'b1;
      cyc(8'h00, 8'h00, 8'h00, 1'b0, "t6_mid_reset");
      rst = 1'b0;
      for (int e = 1; e <= 7; e++)
         cyc((e >= 6) ? 8'h80 : 8'h00, (e >= 6) ? 8'h80 : 8'h00, 8'h00, (e >= 6), "t6_new_window");

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(posedge clk);
      if (sb_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/risc_v_mike_gpio_in_cond.md
Name: risc_v_mike_gpio_in_cond

Overview:
- Input-conditioning stage directly upstream of the core's `gpio_port_in`.
- Takes raw, asynchronous board pins and, per bit, applies a 2-flop synchronizer, a debounce filter and edge detection.
- Presents a clean, stable vector to the core.
- Optionally records sticky rise/fall flags and drives an interrupt-request line.

Parameters:
- GPIO_W, default GPIO_BYTE (8): number of pins conditioned.
- DEBOUNCE_CYCLES, default 4: consecutive differing synchronized samples required before a change is accepted; legal range is ≥1.
- CNT_W, localparam: max(1, $clog2(DEBOUNCE_CYCLES)); debounce counter width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pin_async  in  GPIO_W  raw asynchronous pin levels.
- gpio_in  out  GPIO_W  debounced stable levels; connects to the core's `gpio_port_in`.
- rise_en  in  GPIO_W  per-bit enable of rise flags into irq.
- fall_en  in  GPIO_W  per-bit enable of fall flags into irq.
- flag_clr  in  GPIO_W  single-cycle write-1-to-clear pulse applied to both rise_flag and fall_flag.
- rise_flag  out  GPIO_W  sticky rising-edge flags.
- fall_flag  out  GPIO_W  sticky falling-edge flags.
- irq  out  1  OR of enabled flags.

Behaviour:
- Reset, sampled at the rising edge while rst=1:
  - sync1, sync2, stable (gpio_in), counters, rise_flag and fall_flag all become 0.
  - irq is therefore 0.
  - Reset asserted mid-debounce or mid-bounce discards all progress; there is no pending update after reset.
- Synchronizer: sync1 <= pin_async; sync2 <= sync1. Debounce and edge logic use only sync2.
- Debounce, per bit i, evaluated at each edge:
  - If sync2[i] == stable[i]: cnt[i] <= 0.
  - Otherwise, if cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= sync2[i] and cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
- Debounce consequences:
  - Any sample equal to stable restarts the count. A glitch lasting fewer than DEBOUNCE_CYCLES sync2 samples never reaches gpio_in.
  - Latency: a clean step reaches gpio_in on the (DEBOUNCE_CYCLES+2)-th rising edge, counting the edge that first samples the new pin level as edge 1. This is 6 at the default.
  - With DEBOUNCE_CYCLES=1 the latency is 3 edges and the counter is always 0.
  - The counter never exceeds DEBOUNCE_CYCLES-1; there is no wrap.
- Bits are fully independent; simultaneous changes on several bits are each filtered and flagged separately.
- Edge flags, updated on the same edge as stable[i]:
  - A 0→1 update sets rise_flag[i]; a 1→0 update sets fall_flag[i].
  - Flags hold until cleared; flag_clr[i]=1 clears both flags of bit i.
  - If a set and a clear land on the same edge, set wins.
  - Flags are recorded regardless of rise_en/fall_en.
- irq is combinational from registers: |((rise_flag & rise_en) | (fall_flag & fall_en)). It asserts in the same cycle the flag becomes visible.
- No handshake with the core; gpio_in is level-valid every cycle.

Optional Feature:
- Macro: RISC_V_MIKE_GPIO_EDGE_IRQ_EN.
- Defined: the edge-flag registers, flag_clr handling and irq logic are built as above.
- Undefined:
  - Edge-flag registers and irq logic are not synthesized.
  - rise_flag, fall_flag and irq are tied to 0.
  - rise_en, fall_en and flag_clr are ignored.
  - Ports remain present so instantiations do not change; sync and debounce behaviour is identical.

Decomposition:
- Package risc_v_mike_pkg gains:
  - GPIO_DEBOUNCE_CYCLES (default 4);
  - typedef gpio_vec_t, logic [GPIO_BYTE-1:0].
- Sub-module risc_v_mike_gpio_debounce_bit: one bit of synchronizer, counter and stable register, plus rise/fall pulses.
  - Top instantiates GPIO_W copies in a generate loop.
  - Flag, clear and irq logic stays in the top.

Test Plan:
1. Reset: pin_async=0xFF with rst=1 for 3 cycles → gpio_in=0x00, flags=0x00, irq=0. Release rst, hold pins → gpio_in=0xFF on edge 6 after release, rise_flag=0xFF.
2. Clean step, default DEBOUNCE_CYCLES=4: pin[0] goes 0→1 before edge k → gpio_in[0]=1 after edge k+5 and not before. rise_flag[0]=1 at the same edge. With rise_en=0x01, irq=1 that cycle.
3. Glitch: pin[3] high for exactly 3 cycles then low → gpio_in[3] stays 0, rise_flag[3]=0, irq=0 throughout.
4. Bounce: pin[5] pattern 1,0,1,1,0 (one cycle each), then held 1 → exactly one 0→1 on gpio_in[5], occurring DEBOUNCE_CYCLES+2 edges after the final steady 1. Exactly one rise_flag set and no fall_flag.
5. Clear race: rise_flag[2]=1; flag_clr=0x04 pulsed on the same edge as a new falling update of bit 2 → rise_flag[2]=0, fall_flag[2]=1. flag_clr pulsed on the same edge as a rise → rise_flag[2] stays 1.
6. Reset mid-debounce and macro off:
   - rst pulsed when cnt=2 → no later gpio_in change unless the pin persists a full new window.
   - Build without RISC_V_MIKE_GPIO_EDGE_IRQ_EN and rerun test 2 → gpio_in timing identical; rise_flag, fall_flag and irq always 0.
